// File: rtl/vdp_pkg.sv
// rtl/vdp_pkg.sv - shared state encodings and control codes for the VDP CPU port
package vdp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND_WR = 2'd1,
        PEND_RD = 2'd2,
        RD_WAIT = 2'd3
    } vdp_state_e;

    localparam logic [1:0] CMD_RDSETUP = 2'b00;
    localparam logic [1:0] CMD_WRSETUP = 2'b01;
    localparam logic [1:0] CMD_REGWR   = 2'b10;

    // Any code with the top bit set is a register write
    function automatic logic is_regwr(input logic [1:0] code);
        return code[1] == CMD_REGWR[1];
    endfunction

endpackage

// File: rtl/vdp_port_addr.sv
// rtl/vdp_port_addr.sv - VRAM pointer, latch byte and two-write toggle; register-write
// pulse decoded only when VDP_PORT_REGWR_EN is defined
module vdp_port_addr
    import vdp_pkg::*;
#(
    parameter int A = 14,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ctl_wr,
    input  logic [D-1:0] din,
    input  logic         clr_toggle,
    input  logic         ptr_inc,
    output logic [A-1:0] ptr,
    output logic         cmd_rd,
    output logic         reg_we,
    output logic [2:0]   reg_idx,
    output logic [D-1:0] reg_val
);

    logic [A-1:0]   ptr_q, ptr_d;
    logic [D-1:0]   latch_q, latch_d;
    logic           toggle_q, toggle_d;
    logic [2*D-1:0] setup_word;
    logic [1:0]     code;
    logic           second;
    logic           reg_hit;
    logic           load;

    always_comb begin
        second     = ctl_wr && toggle_q;
        code       = din[7:6];
        setup_word = {din, latch_q};
`ifdef VDP_PORT_REGWR_EN
        reg_hit    = second && is_regwr(code);
`else
        reg_hit    = 1'b0;
`endif
        load       = second && !reg_hit;
        cmd_rd     = second && (code == CMD_RDSETUP);

        latch_d  = latch_q;
        toggle_d = toggle_q;
        ptr_d    = ptr_q;
        if (ctl_wr) begin
            toggle_d = !toggle_q;
            if (!toggle_q) latch_d = din;
        end else if (clr_toggle) begin
            toggle_d = 1'b0;
        end
        // A CPU pointer load wins over an increment from the access engine
        if (load) ptr_d = setup_word[A-1:0];
        else if (ptr_inc) ptr_d = ptr_q + A'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= '0;
            latch_q  <= '0;
            toggle_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            latch_q  <= latch_d;
            toggle_q <= toggle_d;
        end
    end

    assign ptr = ptr_q;

`ifdef VDP_PORT_REGWR_EN
    logic         reg_we_q, reg_we_d;
    logic [2:0]   reg_idx_q, reg_idx_d;
    logic [D-1:0] reg_val_q, reg_val_d;

    always_comb begin
        reg_we_d  = reg_hit;
        reg_idx_d = reg_hit ? din[2:0] : reg_idx_q;
        reg_val_d = reg_hit ? latch_q : reg_val_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_we_q  <= 1'b0;
            reg_idx_q <= '0;
            reg_val_q <= '0;
        end else begin
            reg_we_q  <= reg_we_d;
            reg_idx_q <= reg_idx_d;
            reg_val_q <= reg_val_d;
        end
    end

    assign reg_we  = reg_we_q;
    assign reg_idx = reg_idx_q;
    assign reg_val = reg_val_q;
`else
    assign reg_we  = 1'b0;
    assign reg_idx = 3'b000;
    assign reg_val = '0;
`endif

endmodule

// File: rtl/vdp_cpu_port.sv
// rtl/vdp_cpu_port.sv - CPU data/control port arbitrating VRAM against video fetches;
// register-write decode enabled by VDP_PORT_REGWR_EN
module vdp_cpu_port
    import vdp_pkg::*;
#(
    parameter int A = 14,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_sel,
    input  logic         cpu_rw,
    input  logic         cpu_mode,
    input  logic [D-1:0] cpu_din,
    output logic [D-1:0] cpu_dout,
    input  logic [D-1:0] status_in,
    output logic         busy,
    input  logic         vid_req,
    input  logic [A-1:0] vid_addr,
    output logic [D-1:0] vid_data,
    output logic         vid_valid,
    output logic [A-1:0] ram_addr,
    output logic [D-1:0] ram_din,
    output logic         ram_we,
    input  logic [D-1:0] ram_dout,
    output logic         reg_we,
    output logic [2:0]   reg_idx,
    output logic [D-1:0] reg_val
);

    vdp_state_e   state_q, state_d;
    logic [D-1:0] wbyte_q, wbyte_d;
    logic [D-1:0] rbuf_q, rbuf_d;
    logic [D-1:0] cpu_dout_q, cpu_dout_d;
    logic         overrun_q, overrun_d;
    logic         vid_valid_q, vid_valid_d;

    logic         ctl_wr, ctl_rd, dat_wr, dat_rd;
    logic         clr_toggle, ptr_inc, cmd_rd;
    logic [A-1:0] ptr;

    assign ctl_wr = cpu_sel &&  cpu_mode && !cpu_rw;
    assign ctl_rd = cpu_sel &&  cpu_mode &&  cpu_rw;
    assign dat_wr = cpu_sel && !cpu_mode && !cpu_rw;
    assign dat_rd = cpu_sel && !cpu_mode &&  cpu_rw;
    assign busy   = (state_q != IDLE);

    vdp_port_addr #(.A(A), .D(D)) u_addr (
        .clk        (clk),
        .reset      (reset),
        .ctl_wr     (ctl_wr),
        .din        (cpu_din),
        .clr_toggle (clr_toggle),
        .ptr_inc    (ptr_inc),
        .ptr        (ptr),
        .cmd_rd     (cmd_rd),
        .reg_we     (reg_we),
        .reg_idx    (reg_idx),
        .reg_val    (reg_val)
    );

    always_comb begin
        state_d     = state_q;
        wbyte_d     = wbyte_q;
        rbuf_d      = rbuf_q;
        cpu_dout_d  = cpu_dout_q;
        overrun_d   = overrun_q;
        vid_valid_d = vid_req;
        clr_toggle  = 1'b0;
        ptr_inc     = 1'b0;
        ram_addr    = '0;
        ram_din     = '0;
        ram_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (dat_wr) begin
                    wbyte_d = cpu_din;
                    state_d = PEND_WR;
                end else if (dat_rd) begin
                    cpu_dout_d = rbuf_q;
                    state_d    = PEND_RD;
                end else if (cmd_rd) begin
                    state_d = PEND_RD;
                end
            end
            PEND_WR: begin
                if (!vid_req) begin
                    ram_addr = ptr;
                    ram_din  = wbyte_q;
                    ram_we   = 1'b1;
                    ptr_inc  = 1'b1;
                    state_d  = IDLE;
                end
            end
            PEND_RD: begin
                if (!vid_req) begin
                    ram_addr = ptr;
                    state_d  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                rbuf_d  = ram_dout;
                ptr_inc = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Data accesses are only clean when idle; control accesses always land
        if ((dat_wr || dat_rd) && !busy) clr_toggle = 1'b1;
        if ((dat_wr || dat_rd || cmd_rd) && busy) overrun_d = 1'b1;
        if (ctl_rd) begin
            cpu_dout_d = status_in | {{(D-1){1'b0}}, overrun_q};
            overrun_d  = 1'b0;
            clr_toggle = 1'b1;
        end

        if (vid_req) begin
            ram_addr = vid_addr;
            ram_din  = '0;
            ram_we   = 1'b0;
        end

        if (reset) begin
            ram_addr = '0;
            ram_din  = '0;
            ram_we   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wbyte_q     <= '0;
            rbuf_q      <= '0;
            cpu_dout_q  <= '0;
            overrun_q   <= 1'b0;
            vid_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wbyte_q     <= wbyte_d;
            rbuf_q      <= rbuf_d;
            cpu_dout_q  <= cpu_dout_d;
            overrun_q   <= overrun_d;
            vid_valid_q <= vid_valid_d;
        end
    end

    assign cpu_dout  = cpu_dout_q;
    assign vid_valid = vid_valid_q;
    // VRAM read data arrives the cycle after the fetch address, alongside vid_valid
    assign vid_data  = vid_valid_q ? ram_dout : '0;

endmodule
